// File: rtl/firram_ring_seq_if.sv
// Sample write / tap-stream bundle for the FIR ring RAM sequencer.
interface firram_ring_seq_if #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 128
);
    localparam int AW = $clog2(DEPTH);

    logic             clear;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             rd_start;
    logic             busy;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic             q_last;
    logic [AW:0]      q_tap;
    logic [AW:0]      fill;
    logic             ovf;

    modport master (
        output clear, wr_en, wr_data, rd_start,
        input  busy, q, q_valid, q_last, q_tap, fill, ovf
    );
    modport slave (
        input  clear, wr_en, wr_data, rd_start,
        output busy, q, q_valid, q_last, q_tap, fill, ovf
    );
endinterface

// File: rtl/firram_ring_seq.sv
// Circular sample RAM that streams the newest TAPS samples, newest first,
// with zero masking of never-written slots and overwrite detection.
module firram_ring_seq #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 128,
    parameter int TAPS  = 128
) (
    input  logic           clock,
    input  logic           reset_n,
    firram_ring_seq_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_F = DEPTH[AW:0];
    localparam logic [AW:0]   TAPS_F  = TAPS[AW:0];
    localparam logic [AW:0]   KMIN    = DEPTH_F - TAPS_F;
    localparam logic [AW+1:0] DEPTH_W = DEPTH[AW+1:0];

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state, state_nx;

    logic [WIDTH-1:0] ram [DEPTH];
    logic [WIDTH-1:0] ram_q;
    logic [AW-1:0]    wp, wp0, raddr;
    logic [AW:0]      fill, fill0, i, k;
    logic [AW:0]      tap_s1;
    logic             mask_s1;
    logic [1:0]       vld_pipe;
    logic             wr, start, issue, col;
    logic [AW:0]      kc, ic;
    logic [AW+1:0]    ksum;

    assign wr    = bus.wr_en && !bus.clear;
    assign start = (state == IDLE) && bus.rd_start && !bus.clear;
    assign issue = (state == RUN);
    assign raddr = wp0 - i[AW-1:0] - 1'b1;

    // The write landing on wp0+k hits tap DEPTH-k; it is pending while that
    // tap has not been issued yet (same-edge read sees the new word).
    assign kc   = start ? '0 : k;
    assign ic   = start ? '0 : i;
    assign ksum = {1'b0, kc} + {1'b0, ic} + 1'b1;
    assign col  = wr && (start || issue) && (kc >= KMIN) && (ksum <= DEPTH_W);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (i == TAPS_F - 1'b1) state_nx = DRAIN;
            DRAIN:   if (!vld_pipe[0]) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (bus.clear) state_nx = IDLE;
    end

    always_ff @(posedge clock) begin
        if (wr) ram[wp] <= bus.wr_data;
        if (issue) ram_q <= (wr && wp == raddr) ? bus.wr_data : ram[raddr];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wp        <= '0;
            wp0       <= '0;
            fill      <= '0;
            fill0     <= '0;
            i         <= '0;
            k         <= '0;
            tap_s1    <= '0;
            mask_s1   <= 1'b0;
            vld_pipe  <= '0;
            bus.q     <= '0;
            bus.q_tap <= '0;
            bus.q_last <= 1'b0;
            bus.ovf   <= 1'b0;
        end else begin
            bus.ovf <= col;
            if (bus.clear) begin
                wp         <= '0;
                fill       <= '0;
                vld_pipe   <= '0;
                bus.q      <= '0;
                bus.q_tap  <= '0;
                bus.q_last <= 1'b0;
            end else begin
                vld_pipe <= {vld_pipe[0], issue};
                if (wr) begin
                    wp <= wp + 1'b1;
                    if (fill != DEPTH_F) fill <= fill + 1'b1;
                end
                if (start) begin
                    wp0   <= wp;
                    fill0 <= fill;
                    i     <= '0;
                    k     <= {{AW{1'b0}}, bus.wr_en};
                end else if (wr && state != IDLE && k != DEPTH_F) begin
                    k <= k + 1'b1;
                end
                if (issue) begin
                    i       <= i + 1'b1;
                    tap_s1  <= i + 1'b1;
                    mask_s1 <= (i >= fill0);
                end
                if (vld_pipe[0]) begin
                    bus.q      <= mask_s1 ? '0 : ram_q;
                    bus.q_tap  <= tap_s1;
                    bus.q_last <= (tap_s1 == TAPS_F);
                end else begin
                    bus.q_tap  <= '0;
                    bus.q_last <= 1'b0;
                end
            end
        end
    end

    assign bus.q_valid = vld_pipe[1];
    assign bus.busy    = (state != IDLE);
    assign bus.fill    = fill;
endmodule

// File: tb/tb_firram_ring_seq.sv
// Randomised + directed bench: edge-numbered reference model feeds a
// scoreboard that a negedge monitor drains against the DUT stream.
module tb_firram_ring_seq;
    localparam int WIDTH = 36;
    localparam int DEPTH = 8;
    localparam int TAPS  = 4;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    firram_ring_seq_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
    firram_ring_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAPS(TAPS)) dut (
        .clock(clock), .reset_n(reset_n), .bus(bus));

    typedef struct {
        logic [WIDTH-1:0] data;
        int               tap;
        bit               last;
        int               cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mit;
    int tests = 0, fails = 0, cyc = 0;

    // reference state: sample store, write position, fill, one active sequence
    logic [WIDTH-1:0] mem [DEPTH];
    int  wp, fill, e0, wp0, fill0, nwr;
    bit  seq_on, exp_ovf;

    task automatic check(input string name, input longint act_v, input longint exp_v);
        tests++;
        if (act_v != exp_v) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act_v, exp_v, cyc);
        end
    endtask

    task automatic model_reset();
        wp = 0; fill = 0; seq_on = 0; exp_ovf = 0;
        sb.delete();
    endtask

    task automatic chk_zero(input string tag);
        check({tag, " q"}, bus.q, 0);
        check({tag, " q_valid"}, bus.q_valid, 0);
        check({tag, " q_last"}, bus.q_last, 0);
        check({tag, " q_tap"}, bus.q_tap, 0);
        check({tag, " busy"}, bus.busy, 0);
        check({tag, " fill"}, bus.fill, 0);
        check({tag, " ovf"}, bus.ovf, 0);
    endtask

    // Drive one cycle of inputs, advance the model at the edge, return at negedge.
    task automatic tick(input bit w, input logic [WIDTH-1:0] d, input bit s, input bit c);
        bit pre;
        int j, a;
        exp_t it;
        bus.wr_en = w; bus.wr_data = d; bus.rd_start = s; bus.clear = c;
        @(posedge clock);
        cyc++;
        exp_ovf = 0;
        pre = seq_on;
        if (c) begin
            wp = 0; fill = 0; seq_on = 0;
            sb.delete();
        end else begin
            if (pre && cyc == e0 + TAPS + 2) seq_on = 0;
            if (s && !pre) begin
                seq_on = 1; e0 = cyc; wp0 = wp; fill0 = fill; nwr = 0;
            end
            if (w) begin
                mem[wp] = d;
                if (seq_on) begin
                    j = (wp0 - wp + DEPTH) % DEPTH;
                    if (j == 0) j = DEPTH;
                    // tap j is read at edge e0+j; first overwrite before then is an overflow
                    if (nwr < DEPTH && j <= TAPS && cyc <= e0 + j) exp_ovf = 1;
                    nwr++;
                end
                wp = (wp + 1) % DEPTH;
                if (fill < DEPTH) fill++;
            end
            if (seq_on && cyc - e0 >= 1 && cyc - e0 <= TAPS) begin
                j = cyc - e0;
                a = (wp0 - j + DEPTH) % DEPTH;
                it.data = (j > fill0) ? '0 : mem[a];
                it.tap  = j;
                it.last = (j == TAPS);
                it.cyc  = cyc + 1;
                sb.push_back(it);
            end
        end
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial forever begin
        @(negedge clock);
        if (bus.q_valid) begin
            if (sb.size() == 0) check("unexpected q_valid", bus.q_valid, 0);
            else begin
                mit = sb.pop_front();
                check("q", bus.q, mit.data);
                check("q_tap", bus.q_tap, mit.tap);
                check("q_last", bus.q_last, mit.last);
                check("q_valid edge", cyc, mit.cyc);
            end
        end else begin
            check("idle q_tap", bus.q_tap, 0);
            check("idle q_last", bus.q_last, 0);
            if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                void'(sb.pop_front());
                check("missing q_valid", bus.q_valid, 1);
            end
        end
        check("busy", bus.busy, seq_on);
        check("fill", bus.fill, fill);
        check("ovf", bus.ovf, exp_ovf);
    end

    initial begin
        bit w, s, c;
        logic [WIDTH-1:0] d;
        bus.clear = 0; bus.wr_en = 0; bus.wr_data = '0; bus.rd_start = 0;
        model_reset();
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clock);
        chk_zero("reset");
        #2 reset_n = 1'b1;

        // 1..5 then start: 5,4,3,2
        for (int n = 1; n <= 5; n++) tick(1'b1, WIDTH'(n), 1'b0, 1'b0);
        tick(1'b0, '0, 1'b1, 1'b0);
        idle(8);

        // partial fill: 9,7,0,0
        tick(1'b0, '0, 1'b0, 1'b1);
        tick(1'b1, WIDTH'(7), 1'b0, 1'b0);
        tick(1'b1, WIDTH'(9), 1'b0, 1'b0);
        tick(1'b0, '0, 1'b1, 1'b0);
        idle(8);

        // wrap with saturated fill
        tick(1'b0, '0, 1'b0, 1'b1);
        for (int n = 1; n <= 11; n++) tick(1'b1, WIDTH'(n), 1'b0, 1'b0);
        tick(1'b0, '0, 1'b1, 1'b0);
        idle(8);

        // writes every cycle from the start edge: collision on the oldest tap
        for (int n = 0; n < 8; n++) tick(1'b1, WIDTH'(100 + n), n == 0, 1'b0);
        idle(6);

        // rd_start held high: not queued while busy
        repeat (20) tick(1'b0, '0, 1'b1, 1'b0);
        idle(8);

        // clear while tap 2 is on q, then an all-zero stream
        tick(1'b0, '0, 1'b1, 1'b0);
        idle(3);
        tick(1'b0, '0, 1'b0, 1'b1);
        idle(2);
        tick(1'b0, '0, 1'b1, 1'b0);
        idle(8);

        // async reset mid-stream
        for (int n = 0; n < 3; n++) tick(1'b1, WIDTH'(40 + n), 1'b0, 1'b0);
        tick(1'b0, '0, 1'b1, 1'b0);
        idle(3);
        #2 reset_n = 1'b0;
        #1 model_reset();
        chk_zero("async reset");
        repeat (2) @(negedge clock);
        #2 reset_n = 1'b1;

        for (int n = 0; n < 400; n++) begin
            w = ($urandom_range(0, 1) == 1) && (!seq_on || fill0 == DEPTH);
            s = ($urandom_range(0, 4) == 0);
            c = ($urandom_range(0, 39) == 0);
            d = {4'($urandom), $urandom};
            tick(w, d, s, c);
        end
        idle(12);
        check("scoreboard drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
